// File: rtl/if_fetch_queue_if.sv
// Instruction-bus interface for if_fetch_queue: split address/data phases.
// master = fetch unit (issues addresses, receives data); slave = memory side.
interface if_fetch_queue_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req_valid;
  logic              if_req_op;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_data;

  modport master (
    output if_req_valid, if_req_op, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_data
  );

  modport slave (
    input  if_req_valid, if_req_op, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_data
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: issues sequential fetch addresses, tracks the
// PCs of outstanding requests, buffers returned instructions toward decode and
// discards stale responses after a redirect.
// Optional feature: define IFQ_BYPASS_EN to let a response reach decode in the
// same cycle when the queue is empty.
module if_fetch_queue #(
  parameter int                ADDR_W          = 64,
  parameter int                DATA_W          = 64,
  parameter int                INST_W          = 32,
  parameter int                MAX_OUTSTANDING = 2,
  parameter int                IBUF_DEPTH      = 4,
  parameter logic [ADDR_W-1:0] PC_START        = ADDR_W'(64'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  if_fetch_queue_if.master  bus,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              id_ready,
  output logic              stall_req
);

  localparam int OW     = $clog2(MAX_OUTSTANDING + 1);
  localparam int OW1    = OW + 1;
  localparam int PW     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int QW     = $clog2(IBUF_DEPTH);
  localparam int LANE_W = $clog2(DATA_W / 8) - 2;
  localparam int SUM_W  = OW + QW + 2;

  typedef enum logic {BOOT, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q;

  // In-flight PC FIFO: PCs of accepted requests whose responses are still kept.
  logic [ADDR_W-1:0] pcf_mem [MAX_OUTSTANDING];
  logic [PW-1:0]     pcf_wr_q, pcf_rd_q;
  logic [OW-1:0]     pcf_cnt_q;
  // Responses still owed by the bus for requests issued before a redirect.
  logic [OW-1:0]     discard_cnt_q;

  // Instruction queue toward decode.
  logic [INST_W-1:0] ibuf_inst [IBUF_DEPTH];
  logic [ADDR_W-1:0] ibuf_pc   [IBUF_DEPTH];
  logic [QW-1:0]     q_wr_q, q_rd_q;
  logic [QW:0]       q_cnt_q;

  logic [OW:0]       inflight;
  logic              req_ok, addr_hs, resp_keep, bypass, q_push, q_pop, q_empty;
  logic [ADDR_W-1:0] resp_pc;
  logic [INST_W-1:0] resp_inst;

  function automatic logic [PW-1:0] pcf_next(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Everything the bus still owes us, kept or to be dropped.
  assign inflight = {1'b0, pcf_cnt_q} + {1'b0, discard_cnt_q};
  assign q_empty  = (q_cnt_q == '0);
  assign resp_pc  = pcf_mem[pcf_rd_q];

  // Pick the instruction lane of the returned bus word addressed by the PC.
  generate
    if (LANE_W > 0) begin : g_lane
      logic [LANE_W-1:0] lane_idx;
      assign lane_idx  = resp_pc[LANE_W+1:2];
      assign resp_inst = bus.inst_data[lane_idx*INST_W +: INST_W];
    end else begin : g_lane
      assign resp_inst = bus.inst_data[INST_W-1:0];
    end
  endgenerate

  // FSM next state and request gating; reserve queue space for every request.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    req_ok  = 1'b0;
    if (state_q == BOOT) begin
      state_d = RUN;
    end else begin
      req_ok = (inflight < OW1'(MAX_OUTSTANDING)) &&
               ((SUM_W'(inflight) + SUM_W'(q_cnt_q)) < SUM_W'(IBUF_DEPTH)) &&
               !redirect_valid;
    end
  end

  assign bus.if_req_valid = req_ok;
  assign bus.if_req_op    = 1'b0;
  assign bus.inst_addr    = fetch_pc_q;

  assign addr_hs   = req_ok & bus.inst_addr_ok;
  assign resp_keep = bus.inst_data_ok & (discard_cnt_q == '0) &
                     (pcf_cnt_q != '0) & ~redirect_valid;
`ifdef IFQ_BYPASS_EN
  assign bypass    = resp_keep & q_empty & id_ready;
`else
  assign bypass    = 1'b0;
`endif
  assign q_push    = resp_keep & ~bypass;
  assign q_pop     = ~q_empty & id_ready;

  // Head of queue toward decode, or the bypassed response when the queue is empty.
  always_comb begin
    inst_valid = 1'b0;
    inst       = '0;
    inst_pc    = '0;
    if (!q_empty) begin
      inst_valid = 1'b1;
      inst       = ibuf_inst[q_rd_q];
      inst_pc    = ibuf_pc[q_rd_q];
    end else if (bypass) begin
      inst_valid = 1'b1;
      inst       = resp_inst;
      inst_pc    = resp_pc;
    end
  end

  assign stall_req = rst & q_empty & ~bypass;

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= BOOT;
    else      state_q <= state_d;
  end

  // Fetch PC: jump on redirect, advance one instruction per accepted address.
  always_ff @(posedge clk) begin
    if (!rst)                fetch_pc_q <= PC_START;
    else if (redirect_valid) fetch_pc_q <= redirect_pc;
    else if (addr_hs)        fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
  end

  // In-flight PC FIFO pointers and occupancy; a redirect forgets every entry.
  always_ff @(posedge clk) begin
    if (!rst || redirect_valid) begin
      pcf_wr_q  <= '0;
      pcf_rd_q  <= '0;
      pcf_cnt_q <= '0;
    end else begin
      if (addr_hs)   pcf_wr_q <= pcf_next(pcf_wr_q);
      if (resp_keep) pcf_rd_q <= pcf_next(pcf_rd_q);
      if (addr_hs && !resp_keep)      pcf_cnt_q <= pcf_cnt_q + 1'b1;
      else if (!addr_hs && resp_keep) pcf_cnt_q <= pcf_cnt_q - 1'b1;
    end
  end

  // Discard counter: on redirect every owed response becomes stale, except a
  // beat arriving in the redirect cycle itself, which is already dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      discard_cnt_q <= '0;
    end else if (redirect_valid) begin
      if (bus.inst_data_ok && inflight != '0) discard_cnt_q <= OW'(inflight - 1'b1);
      else                                    discard_cnt_q <= OW'(inflight);
    end else if (bus.inst_data_ok && discard_cnt_q != '0) begin
      discard_cnt_q <= discard_cnt_q - 1'b1;
    end
  end

  // Instruction queue pointers and count; a redirect empties it.
  always_ff @(posedge clk) begin
    if (!rst || redirect_valid) begin
      q_wr_q  <= '0;
      q_rd_q  <= '0;
      q_cnt_q <= '0;
    end else begin
      if (q_push) q_wr_q <= q_wr_q + 1'b1;
      if (q_pop)  q_rd_q <= q_rd_q + 1'b1;
      if (q_push && !q_pop)      q_cnt_q <= q_cnt_q + 1'b1;
      else if (!q_push && q_pop) q_cnt_q <= q_cnt_q - 1'b1;
    end
  end

  // Storage writes for the PC FIFO and the instruction queue.
  // NOTE: storage arrays have no reset; the counters above decide which entries are live.
  always_ff @(posedge clk) begin
    if (addr_hs) pcf_mem[pcf_wr_q] <= fetch_pc_q;
    if (q_push) begin
      ibuf_inst[q_wr_q] <= resp_inst;
      ibuf_pc[q_wr_q]   <= resp_pc;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: reset/boot, backpressure, outstanding
// limit, redirect discard, redirect coincident with data and consume, and the
// same-cycle response path (IFQ_BYPASS_EN) versus registered path.
`timescale 1ns/1ps
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        id_ready;
  logic        stall_req;

  always #5 clk = ~clk;

  if_fetch_queue_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  if_fetch_queue #(
    .ADDR_W(64), .DATA_W(64), .INST_W(32), .MAX_OUTSTANDING(2),
    .IBUF_DEPTH(4), .PC_START(64'h8000_0000)
  ) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .bus(bus), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .id_ready(id_ready), .stall_req(stall_req)
  );

  int          tests_run;
  int          tests_failed;
  int          hs_cnt;
  int          h0;
  logic [63:0] bus_q [$];
  logic [95:0] got_q [$];
  bit          aok, dok_en, use_fixed;
  logic [63:0] fixed_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction word stored at a given PC in the bench's memory image.
  function automatic logic [31:0] word_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [63:0] mem_dword(input logic [63:0] a);
    logic [63:0] base;
    base = {a[63:3], 3'b000};
    return {word_of(base | 64'h4), word_of(base)};
  endfunction

  task automatic drive_bus();
    bus.inst_addr_ok = aok;
    bus.inst_data_ok = dok_en && (bus_q.size() != 0);
    if (bus.inst_data_ok) bus.inst_data = use_fixed ? fixed_data : mem_dword(bus_q[0]);
    else                  bus.inst_data = '0;
  endtask

  task automatic apply(input bit a, input bit d, input logic r);
    aok = a; dok_en = d; id_ready = r;
    drive_bus();
    #1;
  endtask

  // One clock: sample at negedge, update bus model at posedge, redrive inputs.
  task automatic tick();
    logic        hs;
    logic [63:0] ha;
    @(negedge clk);
    hs = bus.if_req_valid & bus.inst_addr_ok;
    ha = bus.inst_addr;
    if (hs) hs_cnt++;
    if (inst_valid & id_ready) got_q.push_back({inst_pc, inst});
    @(posedge clk);
    if (bus.inst_data_ok && bus_q.size() != 0) bus_q.delete(0);
    if (hs) bus_q.push_back(ha);
    #1;
    drive_bus();
    #1;
  endtask

  task automatic check_got(input string tag, input int idx, input logic [63:0] pc);
    if (idx < got_q.size()) begin
      check({tag, "_pc"},   got_q[idx][95:32], pc);
      check({tag, "_inst"}, 64'(got_q[idx][31:0]), 64'(word_of(pc)));
    end else begin
      check({tag, "_present"}, 64'(got_q.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0; tests_failed = 0; hs_cnt = 0;
    use_fixed = 1'b0; fixed_data = '0;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus.inst_data = '0;

    // Reset held three cycles.
    apply(0, 0, 0);
    repeat (3) tick();
    check("rst_req_valid",  64'(bus.if_req_valid), 64'(0));
    check("rst_inst_valid", 64'(inst_valid), 64'(0));
    check("rst_inst",       64'(inst), 64'(0));
    check("rst_inst_pc",    inst_pc, 64'(0));
    check("rst_stall",      64'(stall_req), 64'(0));

    // Boot: one idle cycle, then first fetch at PC_START.
    rst = 1'b1; use_fixed = 1'b1; fixed_data = 64'h00000013_00100093;
    apply(1, 0, 0);
    check("boot_no_req", 64'(bus.if_req_valid), 64'(0));
    check("boot_stall",  64'(stall_req), 64'(1));
    tick();
    check("run_req_valid", 64'(bus.if_req_valid), 64'(1));
    check("run_addr",      bus.inst_addr, 64'h8000_0000);
    check("run_op",        64'(bus.if_req_op), 64'(0));
    tick();                     // address 0x80000000 accepted
    apply(1, 1, 0);             // data for 0x80000000, address 0x80000004 accepted
    tick();
    check("boot_valid0", 64'(inst_valid), 64'(1));
    check("boot_inst0",  64'(inst), 64'h0010_0093);
    check("boot_pc0",    inst_pc, 64'h8000_0000);
    apply(0, 1, 0);             // data for 0x80000004
    tick();
    apply(0, 0, 1);
    check("boot_hold_pc", inst_pc, 64'h8000_0000);
    tick();
    check("boot_inst1", 64'(inst), 64'h0000_0013);
    check("boot_pc1",   inst_pc, 64'h8000_0004);
    tick();
    check("boot_drained_valid", 64'(inst_valid), 64'(0));
    check("boot_drained_stall", 64'(stall_req), 64'(1));
    use_fixed = 1'b0;

    // Backpressure: queue fills to IBUF_DEPTH, then requests stop.
    h0 = hs_cnt;
    apply(1, 1, 0);
    repeat (10) tick();
    check("bp_hs_count",   64'(hs_cnt - h0), 64'(4));
    check("bp_req_valid",  64'(bus.if_req_valid), 64'(0));
    check("bp_head_pc",    inst_pc, 64'h8000_0008);
    check("bp_head_inst",  64'(inst), 64'(word_of(64'h8000_0008)));
    got_q.delete();
    apply(0, 0, 1);
    repeat (4) tick();
    check("bp_drain_count", 64'(got_q.size()), 64'(4));
    for (int i = 0; i < 4; i++) check_got("bp_order", i, 64'h8000_0008 + 64'(4 * i));
    check("bp_empty", 64'(inst_valid), 64'(0));

    // Outstanding limit: no data returned, only two addresses accepted.
    h0 = hs_cnt;
    apply(1, 0, 1);
    repeat (5) tick();
    check("ol_hs_count",  64'(hs_cnt - h0), 64'(2));
    check("ol_req_valid", 64'(bus.if_req_valid), 64'(0));
    got_q.delete();
    apply(0, 1, 1);
    check("ol_req_at_data", 64'(bus.if_req_valid), 64'(0));
    repeat (4) tick();
    check("ol_count", 64'(got_q.size()), 64'(2));
    check_got("ol_first",  0, 64'h8000_0018);
    check_got("ol_second", 1, 64'h8000_001C);

    // Redirect with two requests in flight: both responses dropped.
    apply(1, 0, 1);
    repeat (2) tick();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
    apply(1, 0, 1);
    check("rd_req_suppressed", 64'(bus.if_req_valid), 64'(0));
    tick();
    redirect_valid = 1'b0;
    got_q.delete();
    apply(1, 1, 1);
    repeat (8) tick();
    apply(0, 1, 1);
    repeat (4) tick();
    check_got("rd_first",  0, 64'h8000_1000);
    check_got("rd_second", 1, 64'h8000_1004);

    // Redirect coincident with data_ok and head consume.
    redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
    apply(0, 0, 1);
    tick();
    redirect_valid = 1'b0;
    apply(1, 0, 0);
    repeat (2) tick();          // 0x80002000 and 0x80002004 accepted
    apply(0, 1, 0);
    tick();                     // 0x80002000 queued
    apply(1, 0, 0);
    tick();                     // 0x80002008 accepted, two in flight
    check("rc_head_pc", inst_pc, 64'h8000_2000);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_3000;
    apply(1, 1, 1);             // beat for 0x80002004 arrives with redirect
    tick();
    redirect_valid = 1'b0;
    apply(0, 0, 1);
    check("rc_queue_cleared", 64'(inst_valid), 64'(0));
    check("rc_stall",         64'(stall_req), 64'(1));
    apply(0, 1, 1);             // beat for 0x80002008 must still be dropped
    check("rc_drop_same_cycle", 64'(inst_valid), 64'(0));
    tick();
    check("rc_drop_next_cycle", 64'(inst_valid), 64'(0));
    got_q.delete();
    apply(1, 1, 1);
    repeat (6) tick();
    apply(0, 1, 1);
    repeat (4) tick();
    check_got("rc_first", 0, 64'h8000_3000);

    // Response path latency with an empty queue and id_ready=1.
    redirect_valid = 1'b1; redirect_pc = 64'h8000_4004;
    apply(0, 0, 1);
    tick();
    redirect_valid = 1'b0;
    apply(1, 0, 1);
    tick();                     // 0x80004004 accepted
    apply(0, 1, 1);
`ifdef IFQ_BYPASS_EN
    check("byp_valid_same", 64'(inst_valid), 64'(1));
    check("byp_inst_same",  64'(inst), 64'(word_of(64'h8000_4004)));
    check("byp_pc_same",    inst_pc, 64'h8000_4004);
    check("byp_stall_same", 64'(stall_req), 64'(0));
    tick();
    check("byp_not_queued", 64'(inst_valid), 64'(0));
`else
    check("reg_valid_same", 64'(inst_valid), 64'(0));
    check("reg_stall_same", 64'(stall_req), 64'(1));
    tick();
    check("reg_valid_next", 64'(inst_valid), 64'(1));
    check("reg_inst_next",  64'(inst), 64'(word_of(64'h8000_4004)));
    check("reg_pc_next",    inst_pc, 64'h8000_4004);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
